// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and
// the opcode bit that marks a two-byte instruction.
package fetch_pkg;

    // 3-bit state encodings for the fetch sequencer
    localparam logic [2:0] ST_REQ_OP   = 3'd0;
    localparam logic [2:0] ST_WAIT_OP  = 3'd1;
    localparam logic [2:0] ST_ADV_OP   = 3'd2;
    localparam logic [2:0] ST_REQ_ARG  = 3'd3;
    localparam logic [2:0] ST_WAIT_ARG = 3'd4;
    localparam logic [2:0] ST_ADV_ARG  = 3'd5;
    localparam logic [2:0] ST_ISSUE    = 3'd6;
    localparam logic [2:0] ST_DRAIN    = 3'd7;

    // Opcode MSB set means an operand byte follows the opcode
    localparam int OPND_BIT = 7;

    typedef enum logic [2:0] {
        REQ_OP   = ST_REQ_OP,
        WAIT_OP  = ST_WAIT_OP,
        ADV_OP   = ST_ADV_OP,
        REQ_ARG  = ST_REQ_ARG,
        WAIT_ARG = ST_WAIT_ARG,
        ADV_ARG  = ST_ADV_ARG,
        ISSUE    = ST_ISSUE,
        DRAIN    = ST_DRAIN
    } fetch_state_e;

    // States in which the PC is told to step past the byte just fetched
    function automatic logic is_adv_state(input fetch_state_e s);
        return (s == ADV_OP) || (s == ADV_ARG);
    endfunction

    // States in which a memory read is outstanding
    function automatic logic is_wait_state(input fetch_state_e s);
        return (s == WAIT_OP) || (s == WAIT_ARG) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode (and optional operand) bytes at the
// current PC over a req/ack memory port, steps or reloads the external PC,
// and presents complete instructions to decode over valid/ready.
module fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_inc,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  has_operand,
    input  logic                  branch_req,
    input  logic [ADDR_WIDTH-1:0] branch_target
);

    import fetch_pkg::*;

    fetch_state_e            state_q,       state_d;
    logic                    mem_req_q,     mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,    mem_addr_d;
    logic [DATA_WIDTH-1:0]   opcode_q,      opcode_d;
    logic [DATA_WIDTH-1:0]   operand_q,     operand_d;
    logic                    has_operand_q, has_operand_d;
    logic                    instr_valid_q, instr_valid_d;

    // An ack only counts while a request is actually outstanding
    logic                    ack_s;
    logic                    branch_s;

    // Qualify the handshake inputs; a redirect during reset is ignored
    always_comb begin
        ack_s    = mem_ack & mem_req_q;
        branch_s = branch_req & ~reset;
    end

    // Next-state and datapath: sequence opcode/operand reads, hand off, redirect
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        has_operand_d = has_operand_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            REQ_OP: begin
                if (branch_s) begin
                    state_d = REQ_OP;
                end else begin
                    mem_addr_d = pc;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT_OP;
                end
            end

            WAIT_OP: begin
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    if (branch_s) begin
                        state_d = REQ_OP;
                    end else begin
                        opcode_d      = mem_rdata;
                        operand_d     = {DATA_WIDTH{1'b0}};
                        has_operand_d = mem_rdata[OPND_BIT];
                        state_d       = ADV_OP;
                    end
                end else if (branch_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT_OP;
                end
            end

            ADV_OP: begin
                if (branch_s) begin
                    state_d = REQ_OP;
                end else if (has_operand_q) begin
                    state_d = REQ_ARG;
                end else begin
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end

            REQ_ARG: begin
                if (branch_s) begin
                    state_d = REQ_OP;
                end else begin
                    mem_addr_d = pc;
                    mem_req_d  = 1'b1;
                    state_d    = WAIT_ARG;
                end
            end

            WAIT_ARG: begin
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    if (branch_s) begin
                        state_d = REQ_OP;
                    end else begin
                        operand_d = mem_rdata;
                        state_d   = ADV_ARG;
                    end
                end else if (branch_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT_ARG;
                end
            end

            ADV_ARG: begin
                if (branch_s) begin
                    state_d = REQ_OP;
                end else begin
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end

            ISSUE: begin
                // A redirect retires the instruction whether or not decode took it
                if (branch_s || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ_OP;
                end else begin
                    state_d = ISSUE;
                end
            end

            DRAIN: begin
                // Let the abandoned read finish, then throw its data away
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    state_d   = REQ_OP;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
                state_d       = REQ_OP;
            end
        endcase
    end

    // PC controls: load has priority and suppresses the Moore advance pulse
    always_comb begin
        pc_load     = branch_s;
        pc_load_val = branch_target;
        if (branch_s || reset) begin
            pc_inc = 1'b0;
        end else begin
            pc_inc = is_adv_state(state_q);
        end
    end

    // State and output registers; the PC itself lives outside and is not reset here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= REQ_OP;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= {ADDR_WIDTH{1'b0}};
            opcode_q      <= {DATA_WIDTH{1'b0}};
            operand_q     <= {DATA_WIDTH{1'b0}};
            has_operand_q <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            has_operand_q <= has_operand_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // Drive ports straight from the registers
    always_comb begin
        mem_req     = mem_req_q;
        mem_addr    = mem_addr_q;
        opcode      = opcode_q;
        operand     = operand_q;
        has_operand = has_operand_q;
        instr_valid = instr_valid_q;
    end

    // Memory read is outstanding whenever the sequencer sits in a waiting state
    logic outstanding_s;
    always_comb begin
        outstanding_s = is_wait_state(state_q);
    end

    // Unused-by-logic observation point kept for debug probing
    logic unused_s;
    always_comb begin
        unused_s = outstanding_s ^ mem_req_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: models the PC counter and a program
// memory with programmable ack latency; expected instructions are queued
// when memory is set up and popped when the DUT presents them.
module tb_fetch_unit;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] op;
        logic [DW-1:0] arg;
        logic          two;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] pc_load_val;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = 8'h00;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [DW-1:0] opcode;
    logic [DW-1:0] operand;
    logic          has_operand;
    logic          branch_req = 1'b0;
    logic [AW-1:0] branch_target = 8'h00;

    logic          pc_set = 1'b0;
    logic [AW-1:0] pc_set_val = 8'h00;
    logic [DW-1:0] mem [0:255];
    int            ack_delay = 0;
    int            wait_cnt = 0;
    int            xfer_cnt = 0;
    int            req_cnt = 0;
    int            inc_cnt = 0;
    logic          prev_req = 1'b0;
    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .operand(operand),
        .has_operand(has_operand), .branch_req(branch_req), .branch_target(branch_target)
    );

    // PC counter model: load beats increment; pc_set lets the bench seed it
    always @(posedge clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (pc_load === 1'b1) pc <= pc_load_val;
        else if (pc_inc === 1'b1) pc <= pc + 8'd1;
        if (pc_inc === 1'b1) inc_cnt <= inc_cnt + 1;
    end

    // Program memory model: one ack per request after ack_delay wait cycles
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                mem_rdata = mem[mem_addr];
                wait_cnt = 0;
                xfer_cnt++;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (mem_req === 1'b1 && !prev_req) req_cnt++;
        prev_req = (mem_req === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges with the PC seeded; returns in the first REQ_OP cycle (t0)
    task automatic do_reset(input logic [AW-1:0] start_pc);
        reset = 1'b1; branch_req = 1'b0; instr_ready = 1'b0;
        pc_set = 1'b1; pc_set_val = start_pc;
        tick();
        tick();
        reset = 1'b0; pc_set = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(8'h10);
        n_cmp++;
        if ({mem_req, mem_addr, opcode, operand, has_operand, instr_valid, pc_inc, pc_load} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b addr=%h op=%h arg=%h two=%b valid=%b inc=%b load=%b want all 0",
                     mem_req, mem_addr, opcode, operand, has_operand, instr_valid, pc_inc, pc_load);
        end
    endtask

    task automatic test_one_byte();
        exp_t e; int inc0;
        mem[8'h10] = 8'h05; ack_delay = 0;
        do_reset(8'h10);
        inc0 = inc_cnt;
        sb.push_back({8'h05, 8'h00, 1'b0});
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h10}) begin n_bad++; $display("FAIL one_req: req=%b addr=%h want 1/10", mem_req, mem_addr); end
        tick();
        n_cmp++; if ({pc_inc, instr_valid} !== 2'b10) begin n_bad++; $display("FAIL one_adv: inc=%b valid=%b want 1/0", pc_inc, instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL one_latency: valid=%b at t0+3 want 1", instr_valid); end
        e = sb.pop_front();
        n_cmp++; if ({opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL one_instr: got %h/%h/%b want %h/%h/%b", opcode, operand, has_operand, e.op, e.arg, e.two); end
        n_cmp++; if (inc_cnt - inc0 != 1) begin n_bad++; $display("FAIL one_inc_count: got %0d want 1", inc_cnt - inc0); end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL one_accept: valid=%b want 0", instr_valid); end
    endtask

    task automatic test_two_byte();
        exp_t e; int inc0; int req0;
        mem[8'h20] = 8'h83; mem[8'h21] = 8'h7A; ack_delay = 0;
        do_reset(8'h20);
        inc0 = inc_cnt; req0 = req_cnt;
        sb.push_back({8'h83, 8'h7A, 1'b1});
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h20}) begin n_bad++; $display("FAIL two_req_op: req=%b addr=%h want 1/20", mem_req, mem_addr); end
        tick(); tick(); tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h21}) begin n_bad++; $display("FAIL two_req_arg: req=%b addr=%h want 1/21", mem_req, mem_addr); end
        tick();
        n_cmp++; if ({pc_inc, instr_valid} !== 2'b10) begin n_bad++; $display("FAIL two_adv_arg: inc=%b valid=%b want 1/0", pc_inc, instr_valid); end
        tick();
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL two_latency: valid=%b at t0+6 want 1", instr_valid); end
        e = sb.pop_front();
        n_cmp++; if ({opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL two_instr: got %h/%h/%b want %h/%h/%b", opcode, operand, has_operand, e.op, e.arg, e.two); end
        n_cmp++; if (inc_cnt - inc0 != 2 || req_cnt - req0 != 2) begin n_bad++; $display("FAIL two_counts: inc=%0d req=%0d want 2/2", inc_cnt - inc0, req_cnt - req0); end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e; int inc0; int req0; bit seen;
        mem[8'h30] = 8'h11; ack_delay = 0;
        do_reset(8'h30);
        sb.push_back({8'h11, 8'h00, 1'b0});
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_timeout: valid=%b want 1 within 20 cycles", instr_valid); end
        inc0 = inc_cnt; req0 = req_cnt;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({instr_valid, opcode, operand, has_operand, mem_req, pc_inc} !== {1'b1, e, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: valid=%b instr=%h/%h/%b req=%b inc=%b want 1 %h/%h/%b 0 0",
                         i, instr_valid, opcode, operand, has_operand, mem_req, pc_inc, e.op, e.arg, e.two);
            end
        end
        n_cmp++; if (inc_cnt != inc0 || req_cnt != req0) begin n_bad++; $display("FAIL bp_activity: inc=%0d req=%0d want 0/0", inc_cnt - inc0, req_cnt - req0); end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        n_cmp++; if ({instr_valid, mem_req} !== 2'b00) begin n_bad++; $display("FAIL bp_release: valid=%b req=%b want 0/0", instr_valid, mem_req); end
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h31}) begin n_bad++; $display("FAIL bp_next_req: req=%b addr=%h want 1/31", mem_req, mem_addr); end
    endtask

    task automatic test_wait_states();
        exp_t e; int x0; int req0; bit seen;
        mem[8'h50] = 8'h22; ack_delay = 3;
        do_reset(8'h50);
        x0 = xfer_cnt; req0 = req_cnt;
        sb.push_back({8'h22, 8'h00, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if ({mem_req, mem_addr, pc_inc} !== {1'b1, 8'h50, 1'b0}) begin n_bad++; $display("FAIL ws_hold[%0d]: req=%b addr=%h inc=%b want 1/50/0", i, mem_req, mem_addr, pc_inc); end
        end
        tick();
        n_cmp++; if ({mem_req, pc_inc} !== 2'b01) begin n_bad++; $display("FAIL ws_adv: req=%b inc=%b want 0/1", mem_req, pc_inc); end
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL ws_timeout: valid=%b want 1", instr_valid); end
        e = sb.pop_front();
        n_cmp++; if ({opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL ws_instr: got %h/%h/%b want %h/%h/%b", opcode, operand, has_operand, e.op, e.arg, e.two); end
        n_cmp++; if (xfer_cnt - x0 != 1 || req_cnt - req0 != 1) begin n_bad++; $display("FAIL ws_transfers: xfer=%0d req=%0d want 1/1", xfer_cnt - x0, req_cnt - req0); end
        ack_delay = 0;
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    endtask

    task automatic test_branch_drain();
        exp_t e; bit seen;
        mem[8'h60] = 8'h33; mem[8'h40] = 8'h44; ack_delay = 2;
        do_reset(8'h60);
        sb.push_back({8'h44, 8'h00, 1'b0});
        tick();
        branch_req = 1'b1; branch_target = 8'h40;
        #1;
        n_cmp++; if ({pc_load, pc_load_val, pc_inc} !== {1'b1, 8'h40, 1'b0}) begin n_bad++; $display("FAIL br_wait_load: load=%b val=%h inc=%b want 1/40/0", pc_load, pc_load_val, pc_inc); end
        tick();
        branch_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h60}) begin n_bad++; $display("FAIL br_drain_hold[%0d]: req=%b addr=%h want 1/60", i, mem_req, mem_addr); end
            tick();
        end
        n_cmp++; if ({mem_req, instr_valid} !== 2'b00) begin n_bad++; $display("FAIL br_drain_done: req=%b valid=%b want 0/0", mem_req, instr_valid); end
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h40}) begin n_bad++; $display("FAIL br_new_req: req=%b addr=%h want 1/40", mem_req, mem_addr); end
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL br_timeout: valid=%b want 1", instr_valid); end
        e = sb.pop_front();
        n_cmp++; if ({opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL br_instr: got %h/%h/%b want %h/%h/%b", opcode, operand, has_operand, e.op, e.arg, e.two); end
        ack_delay = 0;
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    endtask

    task automatic test_branch_adv();
        exp_t e; bit seen;
        mem[8'h70] = 8'h01; mem[8'h90] = 8'h09; ack_delay = 0;
        // Reset together with a branch while in ADV_OP
        do_reset(8'h70);
        tick(); tick();
        reset = 1'b1; branch_req = 1'b1; branch_target = 8'h90;
        tick();
        reset = 1'b0; branch_req = 1'b0;
        #1;
        n_cmp++;
        if ({mem_req, mem_addr, opcode, operand, has_operand, instr_valid, pc_inc, pc_load} !== 29'd0) begin
            n_bad++;
            $display("FAIL adv_reset_wins: req=%b addr=%h op=%h arg=%h two=%b valid=%b inc=%b load=%b want all 0",
                     mem_req, mem_addr, opcode, operand, has_operand, instr_valid, pc_inc, pc_load);
        end
        // Branch alone while in ADV_OP
        do_reset(8'h70);
        sb.push_back({8'h09, 8'h00, 1'b0});
        tick(); tick();
        n_cmp++; if (pc_inc !== 1'b1) begin n_bad++; $display("FAIL adv_inc: inc=%b want 1", pc_inc); end
        branch_req = 1'b1; branch_target = 8'h90;
        #1;
        n_cmp++; if ({pc_inc, pc_load, pc_load_val} !== {1'b0, 1'b1, 8'h90}) begin n_bad++; $display("FAIL adv_branch: inc=%b load=%b val=%h want 0/1/90", pc_inc, pc_load, pc_load_val); end
        tick();
        branch_req = 1'b0;
        n_cmp++; if ({mem_req, instr_valid} !== 2'b00) begin n_bad++; $display("FAIL adv_no_req: req=%b valid=%b want 0/0", mem_req, instr_valid); end
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'h90}) begin n_bad++; $display("FAIL adv_new_req: req=%b addr=%h want 1/90", mem_req, mem_addr); end
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        e = sb.pop_front();
        n_cmp++; if (!seen || {opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL adv_instr: valid=%b got %h/%h/%b want %h/%h/%b", seen, opcode, operand, has_operand, e.op, e.arg, e.two); end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    endtask

    task automatic test_branch_issue();
        exp_t e; bit seen;
        mem[8'hA0] = 8'h06; mem[8'hB0] = 8'h07; ack_delay = 0;
        do_reset(8'hA0);
        sb.push_back({8'h06, 8'h00, 1'b0});
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        e = sb.pop_front();
        n_cmp++; if (!seen || {opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL iss_first: valid=%b got %h/%h/%b want %h/%h/%b", seen, opcode, operand, has_operand, e.op, e.arg, e.two); end
        instr_ready = 1'b1; branch_req = 1'b1; branch_target = 8'hB0;
        #1;
        n_cmp++; if ({pc_load, pc_load_val} !== {1'b1, 8'hB0}) begin n_bad++; $display("FAIL iss_load: load=%b val=%h want 1/b0", pc_load, pc_load_val); end
        tick();
        instr_ready = 1'b0; branch_req = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL iss_drop: valid=%b want 0", instr_valid); end
        tick();
        n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 8'hB0}) begin n_bad++; $display("FAIL iss_new_req: req=%b addr=%h want 1/b0", mem_req, mem_addr); end
        sb.push_back({8'h07, 8'h00, 1'b0});
        seen = instr_valid;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = instr_valid; end
        e = sb.pop_front();
        n_cmp++; if (!seen || {opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL iss_second: valid=%b got %h/%h/%b want %h/%h/%b", seen, opcode, operand, has_operand, e.op, e.arg, e.two); end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e; int got; int at [3];
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h85; mem[8'h00] = 8'h66; mem[8'h01] = 8'h03;
        ack_delay = 0;
        do_reset(8'hFE);
        sb.push_back({8'h01, 8'h00, 1'b0});
        sb.push_back({8'h85, 8'h66, 1'b1});
        sb.push_back({8'h03, 8'h00, 1'b0});
        instr_ready = 1'b1;
        got = 0;
        for (int c = 1; c <= 40 && got < 3; c++) begin
            tick();
            if (instr_valid === 1'b1) begin
                e = sb.pop_front();
                at[got] = c;
                got++;
                n_cmp++; if ({opcode, operand, has_operand} !== e) begin n_bad++; $display("FAIL b2b_instr[%0d]: got %h/%h/%b want %h/%h/%b", got - 1, opcode, operand, has_operand, e.op, e.arg, e.two); end
            end
        end
        instr_ready = 1'b0;
        n_cmp++;
        if (got != 3 || at[0] != 3 || at[1] != 10 || at[2] != 14) begin
            n_bad++;
            $display("FAIL b2b_timing: count=%0d cycles=%0d/%0d/%0d want 3 at 3/10/14", got, at[0], at[1], at[2]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_one_byte();
        test_two_byte();
        test_backpressure();
        test_wait_states();
        test_branch_drain();
        test_branch_adv();
        test_branch_issue();
        test_back_to_back();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter. Reads the current PC value.
- Issues byte reads to program memory over a req/ack handshake.
- Assembles 1- or 2-byte instructions and hands them to the decode/execute stage over a valid/ready handshake.
- Drives the PC's advance and load controls, and handles branch redirects, including abandoning in-flight fetches.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address
- DATA_WIDTH, 8, width of memory data, opcode and operand

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- pc  input  ADDR_WIDTH  current program counter value
- pc_inc  output  1  one-cycle request to advance PC by 1
- pc_load  output  1  request to load PC with pc_load_val
- pc_load_val  output  ADDR_WIDTH  PC load value
- mem_req  output  1  memory read request
- mem_addr  output  ADDR_WIDTH  read address, registered
- mem_ack  input  1  read complete; mem_rdata valid this cycle
- mem_rdata  input  DATA_WIDTH  read data
- instr_valid  output  1  opcode/operand valid for decode
- instr_ready  input  1  decode accepts the instruction
- opcode  output  DATA_WIDTH  fetched opcode byte
- operand  output  DATA_WIDTH  fetched operand byte; 0 for 1-byte instructions
- has_operand  output  1  instruction is 2 bytes
- branch_req  input  1  redirect fetch; single-cycle pulse from execute
- branch_target  input  ADDR_WIDTH  redirect address

Behaviour:
- Reset (synchronous, active-high), taking effect at the rising edge where reset=1:
  - state=REQ_OP
  - mem_req=0, mem_addr=0, opcode=0, operand=0, has_operand=0, instr_valid=0
  - pc_inc=0, pc_load=0
  - Does not reset the PC itself.
- Reset mid-transaction: mem_req drops at that edge. The memory side must tolerate an abandoned request.
- FSM states: REQ_OP, WAIT_OP, ADV_OP, REQ_ARG, WAIT_ARG, ADV_ARG, ISSUE, DRAIN.
- REQ_OP: mem_addr<=pc, mem_req<=1; next WAIT_OP.
- WAIT_OP: hold mem_req and mem_addr stable until mem_ack=1. On ack:
  - opcode<=mem_rdata, mem_req<=0, operand<=0
  - has_operand<=mem_rdata[OPND_BIT]
  - next ADV_OP.
- ADV_OP: pc_inc=1 (Moore output), so the PC is updated on entry to the next state. Next REQ_ARG if has_operand, else ISSUE.
- REQ_ARG / WAIT_ARG / ADV_ARG: same as the opcode states, but latch operand instead of opcode. ADV_ARG goes to ISSUE.
- ISSUE: instr_valid=1; opcode, operand and has_operand held stable. On instr_ready=1: instr_valid<=0, next REQ_OP.
- mem_ack is ignored when mem_req=0. mem_ack never completes more than one transfer per request.
- Branch (branch_req=1, any state except during reset):
  - pc_load=branch_req and pc_load_val=branch_target, both combinational, same cycle.
  - pc_inc is forced to 0 in that cycle; load has priority.
  - WAIT_OP/WAIT_ARG without ack this cycle: go to DRAIN. mem_req stays 1 until ack, then the data is discarded; next REQ_OP.
  - WAIT_* with ack this cycle: data discarded, mem_req<=0, next REQ_OP.
  - REQ_*, ADV_*: next REQ_OP; no memory request is issued in that cycle.
  - ISSUE: instr_valid<=0, next REQ_OP. If instr_ready=1 in the same cycle, the instruction counts as consumed (handshake completes); the redirect still applies.
  - DRAIN: remains DRAIN until ack.
- Latency with ack in the first WAIT cycle, from the REQ_OP cycle t0:
  - 1-byte instruction: instr_valid at t0+3.
  - 2-byte instruction: instr_valid at t0+6.
- Back-to-back throughput: one 1-byte instruction per 4 cycles.
- Address wrap: the PC wraps naturally (0xFF+1=0x00); no special handling.

Decomposition:
- Package fetch_pkg:
  - state encoding localparams (3 bits)
  - OPND_BIT=7 (opcode MSB set means a 2-byte instruction)
- The FSM and datapath live in one module; no sub-module is warranted.
- The PC itself remains the existing counter instance at the top level:
  - pc_load feeds its load-select input.
  - Gating its advance with pc_inc is done at top level.

Test Plan:
- Reset then 1-byte fetch: pc=0x10, mem[0x10]=0x05, ack one cycle after req → mem_addr=0x10; pc_inc pulses once; instr_valid at t0+3 with opcode=0x05, has_operand=0, operand=0x00.
- 2-byte fetch: mem[0x20]=0x83, mem[0x21]=0x7A → two requests (0x20, then 0x21); two pc_inc pulses; opcode=0x83, operand=0x7A, has_operand=1 at t0+6.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE → outputs stable; no mem_req; no pc_inc. ready=1 → next REQ_OP.
- Wait states: ack delayed 3 cycles → mem_req and mem_addr stay constant throughout; exactly one transfer is captured.
- Branch during WAIT_OP, ack delayed 2 cycles, branch_target=0x40 → pc_load=1 same cycle; DRAIN until ack; discarded data never appears on instr_valid; next mem_addr=0x40.
- Branch in ADV_OP together with reset asserted mid-fetch → reset wins, with all outputs at reset values next cycle. Branch without reset in ADV_OP → pc_inc=0 and pc_load=1 in that cycle.
